// File: rtl/mpu_pkg.sv
// Shared encodings for the multi-context MPU: config selects, fault causes, FSM states.
package mpu_pkg;

  localparam logic [1:0] SEL_BASE_INST  = 2'b00;
  localparam logic [1:0] SEL_LIMIT_INST = 2'b01;
  localparam logic [1:0] SEL_BASE_DATA  = 2'b10;
  localparam logic [1:0] SEL_LIMIT_DATA = 2'b11;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_INST = 2'b01;
  localparam logic [1:0] CAUSE_DATA = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

endpackage

// File: rtl/mpu_seg_check.sv
// One translation channel: base + logical offset and an unsigned limit check.
// MPU_CARRY_FAULT_EN makes a carry out of the addition a fault on a checked channel.
module mpu_seg_check #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] limit_i,
  input  logic [ADDR_W-1:0] logical_i,
  input  logic              check_i,
  output logic [ADDR_W-1:0] phys_o,
  output logic              fault_o
);

`ifdef MPU_CARRY_FAULT_EN
  logic carry;

  assign {carry, phys_o} = {1'b0, base_i} + {1'b0, logical_i};
  assign fault_o         = check_i & ((logical_i >= limit_i) | carry);
`else
  assign phys_o  = base_i + logical_i;
  assign fault_o = check_i & (logical_i >= limit_i);
`endif

endmodule

// File: rtl/mpu_ctx_unit.sv
// Multi-context MPU: per-context base/limit register file, active-context select,
// registered translation and sticky fault. Optional carry fault: MPU_CARRY_FAULT_EN.
//
// state    | meaning
// ST_RUN   | accepting requests, translating and checking
// ST_FAULT | fault latched, requests ignored until fault_ack
module mpu_ctx_unit #(
  parameter int ADDR_W  = 32,
  parameter int NUM_CTX = 4,
  parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [CTX_W-1:0]  cfg_ctx,
  input  logic [1:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_wdata,
  input  logic              ctx_we,
  input  logic [CTX_W-1:0]  ctx_id,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_jump,
  input  logic              req_mem,
  input  logic [ADDR_W-1:0] in_inst_logical,
  input  logic [ADDR_W-1:0] in_data_logical,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] inst_physical,
  output logic [ADDR_W-1:0] data_physical,
  output logic              seg_fault,
  output logic [1:0]        fault_cause,
  output logic [ADDR_W-1:0] fault_addr,
  input  logic              fault_ack
);
  import mpu_pkg::*;

  logic [ADDR_W-1:0] base_inst_q  [NUM_CTX];
  logic [ADDR_W-1:0] limit_inst_q [NUM_CTX];
  logic [ADDR_W-1:0] base_data_q  [NUM_CTX];
  logic [ADDR_W-1:0] limit_data_q [NUM_CTX];
  logic [CTX_W-1:0]  active_ctx_q;

  state_e            state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] inst_phys_q, inst_phys_d;
  logic [ADDR_W-1:0] data_phys_q, data_phys_d;
  logic              seg_fault_q, seg_fault_d;
  logic [1:0]        cause_q, cause_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

  logic [ADDR_W-1:0] inst_phys, data_phys;
  logic              inst_fault, data_fault;

  // Config and context registers update on the same edge that samples a request,
  // so that request naturally sees the old values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        base_inst_q[i]  <= '0;
        limit_inst_q[i] <= '1;
        base_data_q[i]  <= '0;
        limit_data_q[i] <= '1;
      end
      active_ctx_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (cfg_we && (int'(cfg_ctx) == i)) begin
          case (cfg_sel)
            SEL_BASE_INST:  base_inst_q[i]  <= cfg_wdata;
            SEL_LIMIT_INST: limit_inst_q[i] <= cfg_wdata;
            SEL_BASE_DATA:  base_data_q[i]  <= cfg_wdata;
            default:        limit_data_q[i] <= cfg_wdata;
          endcase
        end
      end
      if (ctx_we && (int'(ctx_id) < NUM_CTX)) begin
        active_ctx_q <= ctx_id;
      end
    end
  end

  mpu_seg_check #(.ADDR_W(ADDR_W)) u_inst_chk (
    .base_i    (base_inst_q[active_ctx_q]),
    .limit_i   (limit_inst_q[active_ctx_q]),
    .logical_i (in_inst_logical),
    .check_i   (req_jump),
    .phys_o    (inst_phys),
    .fault_o   (inst_fault)
  );

  mpu_seg_check #(.ADDR_W(ADDR_W)) u_data_chk (
    .base_i    (base_data_q[active_ctx_q]),
    .limit_i   (limit_data_q[active_ctx_q]),
    .logical_i (in_data_logical),
    .check_i   (req_mem),
    .phys_o    (data_phys),
    .fault_o   (data_fault)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      rsp_valid_q  <= 1'b0;
      inst_phys_q  <= '0;
      data_phys_q  <= '0;
      seg_fault_q  <= 1'b0;
      cause_q      <= CAUSE_NONE;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      inst_phys_q  <= inst_phys_d;
      data_phys_q  <= data_phys_d;
      seg_fault_q  <= seg_fault_d;
      cause_q      <= cause_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = 1'b0;
    inst_phys_d  = inst_phys_q;
    data_phys_d  = data_phys_q;
    seg_fault_d  = seg_fault_q;
    cause_d      = cause_q;
    fault_addr_d = fault_addr_q;
    case (state_q)
      ST_RUN: begin
        if (req_valid) begin
          if (inst_fault || data_fault) begin
            state_d      = ST_FAULT;
            seg_fault_d  = 1'b1;
            cause_d      = {data_fault, inst_fault};
            fault_addr_d = inst_fault ? in_inst_logical : in_data_logical;
          end else begin
            rsp_valid_d = 1'b1;
            inst_phys_d = inst_phys;
            data_phys_d = data_phys;
          end
        end
      end
      ST_FAULT: begin
        if (fault_ack) begin
          state_d     = ST_RUN;
          seg_fault_d = 1'b0;
          cause_d     = CAUSE_NONE;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign req_ready     = (state_q == ST_RUN);
  assign rsp_valid     = rsp_valid_q;
  assign inst_physical = inst_phys_q;
  assign data_physical = data_phys_q;
  assign seg_fault     = seg_fault_q;
  assign fault_cause   = cause_q;
  assign fault_addr    = fault_addr_q;

endmodule

// File: tb/tb_mpu_ctx_unit.sv
// Directed vector bench for mpu_ctx_unit with NUM_CTX = 3 (non power of two).
module tb_mpu_ctx_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ctx = '0;
  logic [1:0]  cfg_sel = '0;
  logic [31:0] cfg_wdata = '0;
  logic        ctx_we = 1'b0;
  logic [1:0]  ctx_id = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_jump = 1'b0;
  logic        req_mem = 1'b0;
  logic [31:0] in_inst_logical = '0;
  logic [31:0] in_data_logical = '0;
  logic        rsp_valid;
  logic [31:0] inst_physical;
  logic [31:0] data_physical;
  logic        seg_fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic        fault_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  mpu_ctx_unit #(.ADDR_W(32), .NUM_CTX(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_we(cfg_we), .cfg_ctx(cfg_ctx), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .ctx_we(ctx_we), .ctx_id(ctx_id),
    .req_valid(req_valid), .req_ready(req_ready), .req_jump(req_jump), .req_mem(req_mem),
    .in_inst_logical(in_inst_logical), .in_data_logical(in_data_logical),
    .rsp_valid(rsp_valid), .inst_physical(inst_physical), .data_physical(data_physical),
    .seg_fault(seg_fault), .fault_cause(fault_cause), .fault_addr(fault_addr),
    .fault_ack(fault_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  ctx;
    logic        jump;
    logic        mem;
    logic [31:0] il;
    logic [31:0] dl;
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] addr;
    logic [31:0] ip;
    logic [31:0] dp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] c, input logic [1:0] s, input logic [31:0] d);
    cfg_we = 1'b1; cfg_ctx = c; cfg_sel = s; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_ctx(input logic [1:0] c);
    ctx_we = 1'b1; ctx_id = c;
    tick();
    ctx_we = 1'b0;
  endtask

  task automatic drive_req(input logic j, input logic m, input logic [31:0] il, input logic [31:0] dl);
    req_valid = 1'b1; req_jump = j; req_mem = m;
    in_inst_logical = il; in_data_logical = dl;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_rsp"}, rsp_valid, 0);
    check({tag, "_ip"}, inst_physical, 0);
    check({tag, "_dp"}, data_physical, 0);
    check({tag, "_seg"}, seg_fault, 0);
    check({tag, "_cause"}, fault_cause, 0);
    check({tag, "_faddr"}, fault_addr, 0);
  endtask

  logic [31:0] last_ip, last_dp, held_addr;

  initial begin
    vecs[0] = '{2'd1, 1'b1, 1'b0, 32'h80,       32'h10, 1'b0, 2'b00, 32'h0,        32'h1080,     32'h5010};
    vecs[1] = '{2'd1, 1'b1, 1'b0, 32'h100,      32'h10, 1'b1, 2'b01, 32'h100,      32'h0,        32'h0};
    vecs[2] = '{2'd0, 1'b1, 1'b1, 32'h10,       32'h40, 1'b1, 2'b11, 32'h10,       32'h0,        32'h0};
    vecs[3] = '{2'd0, 1'b0, 1'b1, 32'h10,       32'h40, 1'b1, 2'b10, 32'h40,       32'h0,        32'h0};
    vecs[4] = '{2'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2'b00, 32'h0,  32'h1FF,      32'h2FFF};
    vecs[5] = '{2'd2, 1'b1, 1'b0, 32'hFFFFFFFE, 32'h20, 1'b0, 2'b00, 32'h0,        32'hFFFFFFFE, 32'h10};
    vecs[6] = '{2'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h20, 1'b1, 2'b01, 32'hFFFFFFFF, 32'h0,        32'h0};
`ifdef MPU_CARRY_FAULT_EN
    vecs[7] = '{2'd2, 1'b1, 1'b1, 32'h5,        32'h20, 1'b1, 2'b10, 32'h20,       32'h0,        32'h0};
`else
    vecs[7] = '{2'd2, 1'b1, 1'b1, 32'h5,        32'h20, 1'b0, 2'b00, 32'h0,        32'h5,        32'h10};
`endif
    vecs[8] = '{2'd1, 1'b0, 1'b1, 32'h0,        32'h0,  1'b1, 2'b10, 32'h0,        32'h0,        32'h0};
    vecs[9] = '{2'd1, 1'b1, 1'b0, 32'hFF,       32'h7,  1'b0, 2'b00, 32'h0,        32'h10FF,     32'h5007};

    // Reset
    #1;
    check_reset_vals("rst_hold");
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check_reset_vals("rst_rel");

    // Configuration
    cfg_write(2'd0, 2'b00, 32'h200);
    cfg_write(2'd0, 2'b01, 32'h8);
    cfg_write(2'd0, 2'b10, 32'h3000);
    cfg_write(2'd0, 2'b11, 32'h40);
    cfg_write(2'd1, 2'b00, 32'h1000);
    cfg_write(2'd1, 2'b01, 32'h100);
    cfg_write(2'd1, 2'b10, 32'h5000);
    cfg_write(2'd1, 2'b11, 32'h0);
    cfg_write(2'd2, 2'b10, 32'hFFFFFFF0);
    // Out-of-range context writes must not land anywhere.
    cfg_write(2'd3, 2'b00, 32'hDEAD0000);
    cfg_write(2'd3, 2'b10, 32'hBEEF0000);
    cfg_write(2'd3, 2'b01, 32'h0);
    cfg_write(2'd3, 2'b11, 32'h0);

    last_ip = '0;
    last_dp = '0;
    for (int i = 0; i < 10; i++) begin
      set_ctx(vecs[i].ctx);
      drive_req(vecs[i].jump, vecs[i].mem, vecs[i].il, vecs[i].dl);
      tick();
      req_valid = 1'b0;
      if (!vecs[i].fault) begin
        check($sformatf("v%0d_rsp", i), rsp_valid, 1);
        check($sformatf("v%0d_ip", i), inst_physical, vecs[i].ip);
        check($sformatf("v%0d_dp", i), data_physical, vecs[i].dp);
        check($sformatf("v%0d_seg", i), seg_fault, 0);
        last_ip = vecs[i].ip;
        last_dp = vecs[i].dp;
        tick();
        check($sformatf("v%0d_pulse", i), rsp_valid, 0);
      end else begin
        check($sformatf("v%0d_rsp", i), rsp_valid, 0);
        check($sformatf("v%0d_seg", i), seg_fault, 1);
        check($sformatf("v%0d_cause", i), fault_cause, vecs[i].cause);
        check($sformatf("v%0d_faddr", i), fault_addr, vecs[i].addr);
        check($sformatf("v%0d_ready", i), req_ready, 0);
        check($sformatf("v%0d_iphold", i), inst_physical, last_ip);
        check($sformatf("v%0d_dphold", i), data_physical, last_dp);
        // A harmless request while faulted is ignored.
        drive_req(1'b0, 1'b0, 32'h1, 32'h1);
        tick();
        req_valid = 1'b0;
        check($sformatf("v%0d_ign_rsp", i), rsp_valid, 0);
        check($sformatf("v%0d_ign_seg", i), seg_fault, 1);
        fault_ack = 1'b1;
        tick();
        fault_ack = 1'b0;
        check($sformatf("v%0d_ack_seg", i), seg_fault, 0);
        check($sformatf("v%0d_ack_cause", i), fault_cause, 0);
        check($sformatf("v%0d_ack_ready", i), req_ready, 1);
        check($sformatf("v%0d_ack_faddr", i), fault_addr, vecs[i].addr);
      end
    end

    // Back-to-back requests on ctx 1
    set_ctx(2'd1);
    drive_req(1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    drive_req(1'b1, 1'b0, 32'h20, 32'h4);
    check("b2b_rsp0", rsp_valid, 1);
    check("b2b_ip0", inst_physical, 32'h1010);
    tick();
    req_valid = 1'b0;
    check("b2b_rsp1", rsp_valid, 1);
    check("b2b_ip1", inst_physical, 32'h1020);
    check("b2b_dp1", data_physical, 32'h5004);
    tick();
    check("b2b_end", rsp_valid, 0);

    // Out-of-range context id is ignored; ctx 1 remains active.
    set_ctx(2'd3);
    drive_req(1'b1, 1'b0, 32'h30, 32'h0);
    tick();
    req_valid = 1'b0;
    check("badctx_ip", inst_physical, 32'h1030);

    // Context switch alongside a request: that request uses the old context.
    set_ctx(2'd0);
    drive_req(1'b1, 1'b0, 32'h4, 32'h0);
    ctx_we = 1'b1; ctx_id = 2'd2;
    tick();
    ctx_we = 1'b0;
    drive_req(1'b1, 1'b0, 32'h4, 32'h0);
    check("sw_old_ip", inst_physical, 32'h204);
    check("sw_old_dp", data_physical, 32'h3000);
    tick();
    req_valid = 1'b0;
    check("sw_new_ip", inst_physical, 32'h4);
    check("sw_new_dp", data_physical, 32'hFFFFFFF0);

    // fault_ack while running does nothing.
    fault_ack = 1'b1;
    tick();
    fault_ack = 1'b0;
    check("ack_run_seg", seg_fault, 0);
    check("ack_run_ready", req_ready, 1);

    // Reset asserted asynchronously while faulted.
    set_ctx(2'd1);
    drive_req(1'b1, 1'b0, 32'h200, 32'h0);
    tick();
    req_valid = 1'b0;
    check("pre_rst_seg", seg_fault, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    #1;
    reset_n = 1'b1;
    tick();
    // Registers are back at reset values: base 0, limit all-ones, ctx 0.
    drive_req(1'b1, 1'b1, 32'h5, 32'h9);
    tick();
    req_valid = 1'b0;
    check("post_rst_rsp", rsp_valid, 1);
    check("post_rst_ip", inst_physical, 32'h5);
    check("post_rst_dp", data_physical, 32'h9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
